mux_scan_ctrl: RTL

//  Sequencer for the 16-bit-select bit mux: drives its select line over a contiguous address range,

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_ctrl_if.sv | 16 +
 rtl/mux_scan_packer.sv | 52 +++++
 rtl/mux_scan_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and default widths for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefWordW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word stream from the scan sequencer to its consumer (valid/ready with last).
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW
) ();

  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/mux_scan_packer.sv
// Packs serial samples LSB-first into a word; word_o already includes the current sample.
module mux_scan_packer
  import mux_scan_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] pack_q, pack_d;

  always_comb begin
    word_o = pack_q;
    for (int unsigned k = 0; k < WORD_W; k++) begin
      if (idx_q == IdxW'(k)) word_o[k] = bit_i;
    end
  end

  assign full_o = (idx_q == IdxW'(WORD_W - 1));

  always_comb begin
    pack_d = pack_q;
    idx_d  = idx_q;
    if (flush_i) begin
      pack_d = '0;
      idx_d  = '0;
    end else if (load_i) begin
      pack_d = word_o;
      idx_d  = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= '0;
      idx_q  <= '0;
    end else begin
      pack_q <= pack_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the mux select over an address range, packs the sampled bits into words and streams them.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned WORD_W = DefWordW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] sel_o,
  input  logic              mux_y_i,
  output logic              busy_o,
  output logic              done_o,
  mux_scan_ctrl_if.master   out_if
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              zdone_q, zdone_d;

  logic              pk_load, pk_flush, pk_full;
  logic [WORD_W-1:0] pk_word;
  logic              rem_one, complete, can_load;

  mux_scan_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (pk_load),
    .flush_i (pk_flush),
    .bit_i   (mux_y_i),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

  assign rem_one  = (rem_q == (ADDR_W + 1)'(1));
  assign complete = pk_full || rem_one;
  assign can_load = !valid_q || out_if.ready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    zdone_d  = 1'b0;
    pk_load  = 1'b0;
    pk_flush = 1'b0;

    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (count_i != '0) begin
            state_d  = StScan;
            sel_d    = start_addr_i;
            rem_d    = count_i;
            pk_flush = 1'b1;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      StScan, StHold: begin
        if (abort_i) begin
          state_d  = StIdle;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          pk_flush = 1'b1;
        end else if (!complete) begin
          state_d = StScan;
          pk_load = 1'b1;
          sel_d   = sel_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W + 1)'(1);
        end else if (can_load) begin
          // In HOLD sel still points at the word's last bit, so pk_word is complete here too.
          state_d  = rem_one ? StIdle : StScan;
          pk_flush = 1'b1;
          sel_d    = sel_q + ADDR_W'(1);
          rem_d    = rem_q - (ADDR_W + 1)'(1);
          data_d   = pk_word;
          valid_d  = 1'b1;
          last_d   = rem_one;
        end else begin
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      zdone_q <= zdone_d;
    end
  end

  assign sel_o        = sel_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = zdone_q || (valid_q && out_if.ready && last_q);
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;

endmodule
